// File: rtl/mac_cluster_seq.sv
// Job sequencer in front of a single mac_cluster: configure, stream operand beats, drain the
// pipeline with zero operands, then hold the four accumulator results until the consumer takes them.
module mac_cluster_seq #(
  parameter int unsigned MacConfWidth = 4,
  parameter int unsigned MacMinWidth  = 8,
  parameter int unsigned MacAccWidth  = 32,
  parameter int unsigned LenWidth     = 16,
  parameter int unsigned PipeLat      = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  input  logic [4*MacAccWidth+MacConfWidth-1:0] cmd_cfg_i,
  input  logic [LenWidth-1:0]                 cmd_len_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [4*MacMinWidth-1:0]            in_a_i,
  input  logic [4*MacMinWidth-1:0]            in_b_i,
  output logic                                mac_cset_o,
  output logic [4*MacAccWidth+MacConfWidth-1:0] mac_cfg_o,
  output logic                                mac_en_o,
  output logic [4*MacMinWidth-1:0]            mac_a_o,
  output logic [4*MacMinWidth-1:0]            mac_b_o,
  input  logic [4*MacAccWidth-1:0]            mac_out_i,
  output logic                                res_valid_o,
  input  logic                                res_ready_i,
  output logic [4*MacAccWidth-1:0]            res_data_o,
  output logic                                busy_o
);

  localparam int unsigned CfgWidth   = 4 * MacAccWidth + MacConfWidth;
  localparam int unsigned ResWidth   = 4 * MacAccWidth;
  localparam int unsigned DrainWidth = $clog2(PipeLat + 1);

  typedef enum logic [2:0] {StIdle, StCfg, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [LenWidth-1:0]   cnt_q, cnt_d;
  logic [DrainWidth-1:0] drain_q, drain_d;
  logic [CfgWidth-1:0]   cfg_q, cfg_d;
  logic [ResWidth-1:0]   res_q, res_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= '0;
      cfg_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      cfg_q   <= cfg_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    cfg_d       = cfg_q;
    res_d       = res_q;
    cmd_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    mac_cset_o  = 1'b0;
    mac_en_o    = 1'b0;
    mac_a_o     = '0;
    mac_b_o     = '0;
    res_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          cfg_d   = cmd_cfg_i;
          cnt_d   = cmd_len_i;
          state_d = StCfg;
        end
      end
      StCfg: begin
        mac_cset_o = 1'b1;
        drain_d    = DrainWidth'(PipeLat);
        state_d    = (cnt_q != '0) ? StRun : StDrain;
      end
      StRun: begin
        in_ready_o = 1'b1;
        mac_a_o    = in_a_i;
        mac_b_o    = in_b_i;
        // Pipeline only advances on accepted beats, so gaps freeze it.
        mac_en_o   = in_valid_i;
        if (in_valid_i) begin
          cnt_d = cnt_q - LenWidth'(1);
          if (cnt_q == LenWidth'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        mac_en_o = 1'b1;
        drain_d  = drain_q - DrainWidth'(1);
        if (drain_q == DrainWidth'(1)) begin
          res_d   = mac_out_i;
          state_d = StDone;
        end
      end
      StDone: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mac_cfg_o  = cfg_q;
  assign res_data_o = res_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_mac_cluster_seq.sv
// Bench for mac_cluster_seq with a behavioural mac_cluster model behind it and a result scoreboard.
module tb_mac_cluster_seq;

  localparam int unsigned PipeLat = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [131:0] cmd_cfg = '0;
  logic [15:0]  cmd_len = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_a = '0;
  logic [31:0]  in_b = '0;
  logic         mac_cset;
  logic [131:0] mac_cfg;
  logic         mac_en;
  logic [31:0]  mac_a;
  logic [31:0]  mac_b;
  logic [127:0] mac_out;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_data;
  logic         busy;

  int total = 0;
  int bad = 0;
  int en_tot = 0;
  int cset_tot = 0;
  logic [127:0] sb_q[$];

  always #5 clk = ~clk;

  mac_cluster_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_cfg_i   (cmd_cfg),
    .cmd_len_i   (cmd_len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .mac_cset_o  (mac_cset),
    .mac_cfg_o   (mac_cfg),
    .mac_en_o    (mac_en),
    .mac_a_o     (mac_a),
    .mac_b_o     (mac_b),
    .mac_out_i   (mac_out),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_prod(input logic [7:0] a, input logic [7:0] b,
                                            input logic sgn);
    logic [31:0] xa, xb;
    xa = sgn ? {{24{a[7]}}, a} : {24'b0, a};
    xb = sgn ? {{24{b[7]}}, b} : {24'b0, b};
    return xa * xb;
  endfunction

  // Cluster model: products travel PipeLat-1 stages, then land in the accumulator.
  logic [3:0][31:0] acc;
  logic [PipeLat-2:0][3:0][31:0] st;
  assign mac_out = acc;

  always @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      st  <= '0;
    end else if (mac_cset) begin
      acc <= mac_cfg[131:4];
      st  <= '0;
    end else if (mac_en) begin
      for (int l = 0; l < 4; l++) begin
        acc[l] <= mac_cfg[2] ? acc[l] + st[PipeLat-2][l] : st[PipeLat-2][l];
        st[0][l] <= lane_prod(mac_a[8*l+:8], mac_b[8*l+:8], mac_cfg[3]);
      end
      for (int s = 1; s < PipeLat - 1; s++) st[s] <= st[s-1];
    end
  end

  always @(negedge clk) begin
    if (mac_en) en_tot++;
    if (mac_cset) cset_tot++;
    if (res_valid && res_ready) begin
      if (sb_q.size() == 0) check("sb_empty", 1, 0);
      else check("result", res_data, sb_q.pop_front());
    end
  end

  function automatic logic [131:0] mk_cfg(input logic [31:0] i3, input logic [31:0] i2,
                                          input logic [31:0] i1, input logic [31:0] i0,
                                          input logic [3:0] mode);
    return {i3, i2, i1, i0, mode};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // abort > 0: assert rst after that many accepted beats and discard the job.
  task automatic run_job(input logic [131:0] cfg, input logic [15:0] len, input logic [31:0] a,
                         input logic [31:0] b, input int gap, input int hold, input int abort);
    logic [127:0] exp;
    int sent, c, n, en0, cs0;
    for (int l = 0; l < 4; l++)
      exp[32*l+:32] = cfg[4+32*l+:32] + 32'(len) * lane_prod(a[8*l+:8], b[8*l+:8], cfg[3]);
    sb_q.push_back(exp);
    en0 = en_tot;
    cs0 = cset_tot;
    cmd_valid = 1'b1;
    cmd_cfg   = cfg;
    cmd_len   = len;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("cmd_tmo", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_cfg   = '0;
    check("cset", mac_cset, 1);
    check("busy", busy, 1);
    sent = 0; c = 0; n = 0;
    while (sent < int'(len) && n < 400) begin
      if (abort > 0 && sent == abort) break;
      in_valid = (gap == 0) || (c % (gap + 1) == gap);
      in_a = a;
      in_b = b;
      #1;
      if (in_ready) begin
        c++;
        check("en_gate", mac_en, in_valid);
        check("a_pass", mac_a, a);
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      n++;
    end
    if (abort > 0) begin
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_cmd_rdy", cmd_ready, 1);
      check("rst_res_vld", res_valid, 0);
      check("rst_cfg", mac_cfg, 0);
      void'(sb_q.pop_back());
      return;
    end
    if (sent != int'(len)) check("beat_tmo", sent, len);
    // Junk beats while draining must be ignored and must not reach the cluster.
    in_valid = 1'b1;
    in_a = '1;
    in_b = '1;
    n = 0;
    while (!res_valid && n < 40) begin
      #1;
      check("drain_rdy", in_ready, 0);
      check("drain_a", mac_a, 0);
      check("cfg_hold", mac_cfg, cfg);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    if (!res_valid) begin
      check("res_tmo", 0, 1);
      sb_q.delete();
      do_reset();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_cfg   = mk_cfg(1, 2, 3, 4, 4'b0100);
      #1;
      check("hold_data", res_data, exp);
      check("hold_cmd_rdy", cmd_ready, 0);
      check("done_en", mac_en, 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("taken_vld", res_valid, 0);
    check("taken_cmd_rdy", cmd_ready, 1);
    cmd_valid = 1'b0;
    cmd_cfg   = '0;
    check("en_count", en_tot - en0, int'(len) + PipeLat);
    check("cset_count", cset_tot - cs0, 1);
  endtask

  initial begin
    do_reset();
    check("rst_cmd_rdy", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_in_rdy", in_ready, 0);
    check("rst_res_vld", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_cfg", mac_cfg, 0);
    check("rst_en_cset", {mac_en, mac_cset}, 0);
    run_job(mk_cfg(0, 0, 0, 10, 4'b0100), 16'd3, 32'h3, 32'h4, 0, 0, 0);
    run_job(mk_cfg(0, 0, 0, 10, 4'b0100), 16'd3, 32'h3, 32'h4, 2, 0, 0);
    run_job(mk_cfg(40, 30, 20, 10, 4'b0100), 16'd0, 32'h0, 32'h0, 0, 0, 0);
    run_job(mk_cfg(0, 0, 0, 7, 4'b0100), 16'd2, 32'h9, 32'h2, 0, 5, 0);
    run_job(mk_cfg(0, 0, 0, 0, 4'b1100), 16'd2, 32'hFE, 32'h5, 0, 0, 0);
    run_job(mk_cfg(100, 200, 300, 400, 4'b0110), 16'd5, 32'h04030201, 32'h01020304, 1, 1, 0);
    run_job(mk_cfg(0, 0, 0, 10, 4'b0100), 16'd4, 32'h3, 32'h4, 0, 0, 1);
    run_job(mk_cfg(5, 6, 7, 8, 4'b1111), 16'd4, 32'h80FF7F01, 32'h02FF7F80, 0, 2, 0);
    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) check("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
